// File: rtl/rx_mac_pkg.sv
// Shared types and constants for the MII receive MAC.
package rx_mac_pkg;

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_DROP
  } state_t;

  localparam logic [3:0]  PREAMBLE_NIB = 4'h5;
  localparam logic [3:0]  SFD_NIB      = 4'hD;
  localparam logic [31:0] CRC_POLY     = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT     = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE  = 32'hC704DD7B;

endpackage

// File: rtl/rx_mac_if.sv
// PHY-side MII receive signals plus the user-side nibble stream of the RX MAC.
interface rx_mac_if;

  logic       mii_rx_dv;
  logic       mii_rx_er;
  logic [3:0] mii_rx_dat;
  logic       rx_vld;
  logic       rx_sof;
  logic       rx_eof;
  logic       rx_err;
  logic [3:0] rx_dat;

  modport master (
    input  mii_rx_dv, mii_rx_er, mii_rx_dat,
    output rx_vld, rx_sof, rx_eof, rx_err, rx_dat
  );

  modport slave (
    output mii_rx_dv, mii_rx_er, mii_rx_dat,
    input  rx_vld, rx_sof, rx_eof, rx_err, rx_dat
  );

endinterface

// File: rtl/rx_mac_crc32_nibble.sv
// Combinational CRC-32 update by one nibble (bit 0 first), MSB-first register.
module crc32_nibble
  import rx_mac_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [3:0]  dat,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  always_comb begin
    c = crc_in;
    for (int i = 0; i < 4; i++) begin
      c = {c[30:0], 1'b0} ^ ((c[31] ^ dat[i]) ? CRC_POLY : 32'h0);
    end
  end

  assign crc_out = c;

endmodule

// File: rtl/rx_mac.sv
// 100M MII receive MAC: strips preamble/SFD and FCS, flags bad frames at eof.
// Define RX_MAC_CRC_CHECK_EN to compile in the CRC-32 residue check.
module rx_mac
  import rx_mac_pkg::*;
#(
  parameter int MAX_NIBBLES = 3036
) (
  input logic      clk_rx,
  input logic      rst,
  rx_mac_if.master bus
);

  localparam logic [11:0] CNT_MAX      = 12'hFFF;
  localparam logic [11:0] FULL_CNT     = 12'd9;
  localparam logic [11:0] OVERSIZE_CNT = 12'(MAX_NIBBLES + 8);

  logic        r_dv;
  logic        r_er;
  logic [3:0]  r_dat;
  state_t      state;
  logic [3:0]  dly [9];
  logic [11:0] cnt;
  logic        err_flag;
  logic        sof_pend;
  logic        e_vld;
  logic        e_sof;
  logic        e_eof;
  logic        e_err;
  logic [3:0]  e_dat;
  logic        sfd_hit;
  logic        crc_bad;
  logic        frame_bad;

  // r_dv resets high so WAIT only leaves after a genuinely sampled dv=0.
  always_ff @(posedge clk_rx or posedge rst) begin
    if (rst) begin
      r_dv  <= 1'b1;
      r_er  <= 1'b0;
      r_dat <= 4'h0;
    end else begin
      r_dv  <= bus.mii_rx_dv;
      r_er  <= bus.mii_rx_er;
      r_dat <= bus.mii_rx_dat;
    end
  end

  assign sfd_hit = (state == ST_PREAMBLE) && r_dv && (r_dat == SFD_NIB);

`ifdef RX_MAC_CRC_CHECK_EN
  logic [31:0] crc_q;
  logic [31:0] crc_next;

  crc32_nibble u_crc (
    .crc_in  (crc_q),
    .dat     (r_dat),
    .crc_out (crc_next)
  );

  always_ff @(posedge clk_rx or posedge rst) begin
    if (rst) begin
      crc_q <= CRC_INIT;
    end else if (sfd_hit) begin
      crc_q <= CRC_INIT;
    end else if ((state == ST_DATA) && r_dv) begin
      crc_q <= crc_next;
    end
  end

  assign crc_bad = (crc_q != CRC_RESIDUE);
`else
  assign crc_bad = 1'b0;
`endif

  // cnt includes the 8 FCS nibbles, so parity and size limits shift by 8.
  assign frame_bad = err_flag | cnt[0] | (cnt > OVERSIZE_CNT) | crc_bad;

  always_ff @(posedge clk_rx or posedge rst) begin
    if (rst) begin
      state    <= ST_WAIT;
      cnt      <= 12'd0;
      err_flag <= 1'b0;
      sof_pend <= 1'b0;
      e_vld    <= 1'b0;
      e_sof    <= 1'b0;
      e_eof    <= 1'b0;
      e_err    <= 1'b0;
      e_dat    <= 4'h0;
      for (int i = 0; i < 9; i++) dly[i] <= 4'h0;
    end else begin
      e_vld <= 1'b0;
      e_sof <= 1'b0;
      e_eof <= 1'b0;
      e_err <= 1'b0;
      case (state)
        ST_WAIT: begin
          if (!r_dv) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (r_dv) state <= (r_dat == PREAMBLE_NIB) ? ST_PREAMBLE : ST_DROP;
        end
        ST_PREAMBLE: begin
          if (!r_dv) begin
            state <= ST_IDLE;
          end else if (sfd_hit) begin
            state    <= ST_DATA;
            cnt      <= 12'd0;
            err_flag <= 1'b0;
            sof_pend <= 1'b1;
            for (int i = 0; i < 9; i++) dly[i] <= 4'h0;
          end else if (r_dat != PREAMBLE_NIB) begin
            state <= ST_DROP;
          end
        end
        ST_DATA: begin
          if (r_dv) begin
            dly[0] <= r_dat;
            for (int i = 1; i < 9; i++) dly[i] <= dly[i-1];
            if (cnt != CNT_MAX) cnt <= cnt + 12'd1;
            if (r_er) err_flag <= 1'b1;
            if (cnt >= FULL_CNT) begin
              e_vld    <= 1'b1;
              e_sof    <= sof_pend;
              e_dat    <= dly[8];
              sof_pend <= 1'b0;
            end
          end else begin
            state    <= ST_IDLE;
            sof_pend <= 1'b0;
            if (cnt >= FULL_CNT) begin
              e_vld <= 1'b1;
              e_sof <= sof_pend;
              e_eof <= 1'b1;
              e_err <= frame_bad;
              e_dat <= dly[8];
            end
          end
        end
        ST_DROP: begin
          if (!r_dv) state <= ST_IDLE;
        end
        default: state <= ST_WAIT;
      endcase
    end
  end

  always_ff @(posedge clk_rx or posedge rst) begin
    if (rst) begin
      bus.rx_vld <= 1'b0;
      bus.rx_sof <= 1'b0;
      bus.rx_eof <= 1'b0;
      bus.rx_err <= 1'b0;
      bus.rx_dat <= 4'h0;
    end else begin
      bus.rx_vld <= e_vld;
      bus.rx_sof <= e_sof;
      bus.rx_eof <= e_eof;
      bus.rx_err <= e_err;
      bus.rx_dat <= e_dat;
    end
  end

endmodule

// File: tb/tb_rx_mac.sv
// Scoreboard bench for rx_mac: directed frames, expected nibbles queued at drive time.
module tb_rx_mac;

  typedef struct {
    logic [3:0] dat;
    logic       sof;
    logic       eof;
    logic       err;
    int         cyc;
  } exp_t;

`ifdef RX_MAC_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  rx_mac_if bus ();

  rx_mac dut (
    .clk_rx (clk),
    .rst    (rst),
    .bus    (bus.master)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] crcNib(input logic [31:0] c, input logic [3:0] d);
    logic [31:0] r;
    r = c;
    for (int b = 0; b < 4; b++) begin
      if (r[31] ^ d[b]) r = (r << 1) ^ 32'h04C11DB7;
      else              r = r << 1;
    end
    return r;
  endfunction

  task automatic driveNib(input logic dv, input logic er, input logic [3:0] d);
    @(negedge clk);
    bus.mii_rx_dv  = dv;
    bus.mii_rx_er  = er;
    bus.mii_rx_dat = d;
  endtask

  // Raw nibble sequences that must produce no output, followed by a 1-cycle gap.
  task automatic driveRaw(input logic [3:0] seq[$]);
    foreach (seq[i]) driveNib(1'b1, 1'b0, seq[i]);
    driveNib(1'b0, 1'b0, 4'h0);
  endtask

  task automatic applyStimulus(input int n_data, input int flip_at, input int er_at, input int abort_at);
    logic [3:0]  d[$];
    logic [31:0] c;
    logic [31:0] fcs;
    logic [3:0]  nib;
    logic        exp_err;
    bit          aborted;
    exp_t        e;
    aborted = 1'b0;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n_data; i++) begin
      nib = 4'(i * 3 + n_data);
      d.push_back(nib);
      c = crcNib(c, nib);
    end
    fcs = ~c;
    for (int j = 0; j < 8; j++) begin
      for (int b = 0; b < 4; b++) nib[b] = fcs[31 - (4 * j + b)];
      d.push_back(nib);
    end
    if (flip_at >= 0) d[flip_at] = d[flip_at] ^ 4'h1;
    exp_err = (n_data % 2 == 1) || (er_at >= 0) || (n_data > 3036) || ((flip_at >= 0) && CRC_EN);
    for (int i = 0; i < 15; i++) driveNib(1'b1, 1'b0, 4'h5);
    driveNib(1'b1, 1'b0, 4'hD);
    for (int i = 0; i < n_data + 8; i++) begin
      driveNib(1'b1, (i == er_at), d[i]);
      if (i == abort_at) begin
        sb.delete();
        rst = 1'b1;
        aborted = 1'b1;
        #1;
        checkOutput("abort_vld", {31'b0, bus.rx_vld}, 32'd0);
        checkOutput("abort_sof", {31'b0, bus.rx_sof}, 32'd0);
        checkOutput("abort_dat", {28'b0, bus.rx_dat}, 32'd0);
      end
      if (aborted && i == abort_at + 2) rst = 1'b0;
      if (!aborted && i < n_data) begin
        e.dat = d[i];
        e.sof = (i == 0);
        e.eof = (i == n_data - 1);
        e.err = (i == n_data - 1) ? exp_err : 1'b0;
        e.cyc = cyc + 12;
        sb.push_back(e);
      end
    end
    driveNib(1'b0, 1'b0, 4'h0);
  endtask

  // Monitor: pops one expected nibble per rx_vld and checks content and timing.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (bus.rx_vld === 1'b1) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_vld", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("nibble",
                      {25'b0, bus.rx_sof, bus.rx_eof, (bus.rx_eof & bus.rx_err), bus.rx_dat},
                      {25'b0, e.sof, e.eof, (e.eof & e.err), e.dat});
          checkOutput("latency", cyc, e.cyc);
        end
      end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checkOutput("missing_vld", 32'd0, 32'd1);
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] q[$];
    rst = 1'b1;
    bus.mii_rx_dv  = 1'b0;
    bus.mii_rx_er  = 1'b0;
    bus.mii_rx_dat = 4'h0;
    repeat (3) @(negedge clk);
    checkOutput("reset_vld", {31'b0, bus.rx_vld}, 32'd0);
    checkOutput("reset_sof", {31'b0, bus.rx_sof}, 32'd0);
    checkOutput("reset_eof", {31'b0, bus.rx_eof}, 32'd0);
    checkOutput("reset_err", {31'b0, bus.rx_err}, 32'd0);
    checkOutput("reset_dat", {28'b0, bus.rx_dat}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] good frame, 128 nibbles");
    applyStimulus(128, -1, -1, -1);
    $display("[TB] bit flip in data nibble 20");
    applyStimulus(128, 20, -1, -1);
    $display("[TB] rx_er at data nibble 40");
    applyStimulus(128, -1, 40, -1);

    $display("[TB] runt of 6 nibbles, then good frame");
    q = {};
    for (int i = 0; i < 15; i++) q.push_back(4'h5);
    q.push_back(4'hD);
    for (int i = 0; i < 6; i++) q.push_back(4'hA);
    driveRaw(q);
    applyStimulus(32, -1, -1, -1);

    $display("[TB] runt of 8 nibbles, then good frame");
    q = {4'h5, 4'h5, 4'h5, 4'h5, 4'hD};
    for (int i = 0; i < 8; i++) q.push_back(4'h3);
    driveRaw(q);
    applyStimulus(20, -1, -1, -1);

    $display("[TB] bad preamble, then good frame");
    q = {4'h5, 4'h5, 4'h7, 4'h5, 4'h5, 4'hD};
    for (int i = 0; i < 30; i++) q.push_back(4'(i));
    driveRaw(q);
    applyStimulus(40, -1, -1, -1);

    $display("[TB] single-nibble and two-nibble frames");
    applyStimulus(1, -1, -1, -1);
    applyStimulus(2, -1, -1, -1);

    $display("[TB] reset at data nibble 50, then good frame");
    applyStimulus(128, -1, -1, 50);
    applyStimulus(64, -1, -1, -1);

    $display("[TB] size limit frames");
    applyStimulus(3036, -1, -1, -1);
    applyStimulus(3038, -1, -1, -1);

    for (int i = 0; i < 60 && sb.size() > 0; i++) @(negedge clk);
    checkOutput("drain", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rx_mac.md
# rx_mac

100M MII Ethernet receive MAC: the receive-side counterpart of the MII TX MAC. Samples the PHY nibble stream, strips preamble/SFD, removes the 4-byte FCS and delivers frame data nibbles to the user with start/end/error flags. Checks the CRC-32 residue and frame sanity, and reports failures on the end-of-frame nibble. No backpressure: MII cannot stall, so the user must accept every valid nibble.

## Interface

- MAX_NIBBLES, 3036, maximum data nibbles (excluding FCS) before the frame is flagged oversize; 3036 = 1518 bytes.

- clk_rx  in  1  MII receive clock, 25 MHz; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- mii_rx_dv  in  1  PHY receive data valid.
- mii_rx_er  in  1  PHY receive error.
- mii_rx_dat  in  4  PHY receive nibble, bit 0 first on the wire.
- rx_vld  out  1  rx_dat holds a frame data nibble.
- rx_sof  out  1  first data nibble of a frame; qualified by rx_vld.
- rx_eof  out  1  last data nibble of a frame; qualified by rx_vld.
- rx_err  out  1  frame bad; valid only with rx_vld && rx_eof.
- rx_dat  out  4  data nibble, same nibble order as the wire.

## Operation

- MII inputs are registered once on entry. All decisions use the registered copies.
- States: WAIT, IDLE, PREAMBLE, DATA, DROP.
  - WAIT (reset state): wait for dv=0, then go to IDLE. This rejects a frame that is already in progress when reset is released.
  - IDLE: dv=1 with nibble 0x5 -> PREAMBLE; dv=1 with any other nibble -> DROP.
  - PREAMBLE: 0x5 -> stay; 0xD (SFD) -> DATA and clear the buffer, counter, error flag and CRC; any other nibble -> DROP; dv=0 -> IDLE.
  - DATA: each dv=1 nibble is shifted into a 9-nibble delay buffer and into the CRC. dv=0 -> IDLE and perform end-of-frame handling.
  - DROP: ignore all input until dv=0, then go to IDLE.
- Output: once the buffer holds 9 nibbles, each new nibble pushes the oldest out onto rx_dat with rx_vld=1. rx_sof=1 on the first nibble pushed out.
- End of frame (first dv=0 cycle in DATA):
  - If the buffer is full, emit its oldest nibble with rx_vld=rx_eof=1. That nibble is the last data nibble; the remaining 8 are the FCS and are discarded.
  - If fewer than 9 nibbles were received, the frame is a runt: emit nothing and raise no error.
- CRC-32 update per nibble:
  - Polynomial 0x04C11DB7, MSB-first register, initial value 0xFFFFFFFF.
  - Data bits fed bit 0 first.
  - Run over data and FCS nibbles.
  - A good frame leaves residue 0xC704DD7B.
- rx_err at rx_eof is the OR of:
  - mii_rx_er seen at any point in DATA (sticky flag);
  - an odd number of data nibbles;
  - data nibble count > MAX_NIBBLES (counter is 12-bit and saturating);
  - CRC residue mismatch, only when the CRC check is enabled (see Configuration).
- mii_rx_er outside DATA is ignored.

## Timing

- Reset values: rx_vld=0, rx_sof=0, rx_eof=0, rx_err=0, rx_dat=0. State = WAIT.
- All outputs are registered.
- Latency: a data nibble sampled at rising edge n is driven on rx_dat from edge n+11. Latency is constant within a frame.
- The eof nibble appears 2 edges after the edge that samples dv=0.
- rx_vld is high for exactly N cycles per frame, where N = data nibbles. rx_vld is contiguous, because the MII stream is gap-free.
- rx_sof and rx_eof fall in the same cycle when N=1 (an odd count, so rx_err=1).
- Back-to-back frames: a single dv=0 cycle between frames is sufficient. The next preamble is accepted from IDLE while the previous frame's eof is still being emitted.
- dv dropping in the same cycle that the 9th nibble would have arrived counts as a runt.
- Reset asserted mid-frame: outputs clear immediately and no eof is emitted for the aborted frame.

## Configuration

- RX_MAC_CRC_CHECK_EN defined:
  - CRC logic is compiled in.
  - A residue mismatch sets rx_err.
- RX_MAC_CRC_CHECK_EN undefined:
  - No CRC logic.
  - FCS is still stripped.
  - rx_err reflects only mii_rx_er, odd count and oversize.

## Structure

- Package rx_mac_pkg holds:
  - the state enum;
  - PREAMBLE_NIB=4'h5 and SFD_NIB=4'hD;
  - CRC_POLY=32'h04C11DB7;
  - CRC_INIT=32'hFFFFFFFF;
  - CRC_RESIDUE=32'hC704DD7B.
- One sub-module, crc32_nibble: combinational 4-bit update of a 32-bit CRC. It is shareable with the TX path and is instantiated only under RX_MAC_CRC_CHECK_EN.

## Test plan

- Good frame: 15x 0x5, 0xD, 64 data bytes (128 nibbles) with a correct FCS -> 128 rx_vld cycles; rx_sof on nibble 0; rx_eof on nibble 127; rx_err=0; first nibble appears 11 edges after it is sampled.
- Same frame with one data bit flipped -> identical data stream; rx_err=1 at eof with RX_MAC_CRC_CHECK_EN defined, rx_err=0 without it.
- mii_rx_er pulsed for one cycle at data nibble 40 -> frame delivered in full with rx_err=1.
- Runt: SFD followed by 6 nibbles, then dv=0 -> no rx_vld at all. A good frame after a 1-cycle gap is delivered correctly.
- Bad preamble: 0x5 0x5 0x7 ... 0xD ... -> DROP; no output until dv=0; the next good frame is received.
- Reset asserted at data nibble 50 and released while dv=1 -> outputs 0 immediately; rest of that frame ignored (WAIT); the following frame is received normally.
